// File: rtl/mem_unit.sv
// mem_unit: single-port memory with a downward-growing hardware stack, 1-cycle read/pop.
// Optional write protection of the code region: MEM_UNIT_WPROT_EN.
module mem_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int STACK_BASE  = 2**ADDR_W-1,
  parameter int STACK_LIMIT = 2**ADDR_W-32,
  parameter int CODE_TOP    = 2**ADDR_W/2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] sp,
  output logic              stk_empty,
  output logic              stk_full,
  output logic [3:0]        err
);
`ifdef MEM_UNIT_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(STACK_LIMIT-1);
  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(CODE_TOP);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [ADDR_W-1:0] sp_q, sp_d, waddr, raddr;
  logic [3:0]        err_q, err_d;
  logic do_push, do_pop, do_we, do_re, prot_we, prot_push, push_ok, pop_ok, wen, ren;
  assign stk_empty = sp_q == BASE;
  assign stk_full  = sp_q == FULL;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign sp        = sp_q;
  assign err       = err_q;
  // Grant by priority push > pop > we > re; push with pop cancels everything.
  always_comb begin
    do_push   = push & ~pop;
    do_pop    = pop & ~push;
    do_we     = we & ~push & ~pop;
    do_re     = re & ~push & ~pop & ~we;
    prot_we   = WPROT & do_we & (addr < TOP);
    prot_push = WPROT & do_push & (sp_q < TOP);
    push_ok   = do_push & ~stk_full & ~prot_push;
    pop_ok    = do_pop & ~stk_empty;
    wen       = push_ok | (do_we & ~prot_we);
    waddr     = push_ok ? sp_q : addr;
    ren       = pop_ok | do_re;
    raddr     = pop_ok ? sp_q + 1'b1 : addr;
    sp_d      = push_ok ? sp_q - 1'b1 : pop_ok ? sp_q + 1'b1 : sp_q;
    err_d     = err_q | {prot_we | prot_push, $countones({push, pop, we, re}) > 1,
                         do_pop & stk_empty, do_push & stk_full};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sp_q     <= BASE;
      err_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sp_q     <= sp_d;
      err_q    <= err_d;
      rvalid_q <= ren;
      if (ren) rdata_q <= mem_q[raddr];
    end
  always_ff @(posedge clk)
    if (wen && !rst) mem_q[waddr] <= wdata;
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed plan steps plus randomized traffic against a behavioural memory/stack model.
module tb_mem_unit;
`ifdef MEM_UNIT_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic re = 0, we = 0, push = 0, pop = 0;
  logic [7:0] addr = 0, wdata = 0;
  logic [7:0] rdata, sp;
  logic rvalid, stk_empty, stk_full;
  logic [3:0] err;
  int n = 0, nf = 0;
  logic [7:0] m [256];
  bit known [256];
  int msp;
  logic [3:0] me;
  logic [7:0] mrd;
  bit mrv, mrdk;

  mem_unit dut (.clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
                .push(push), .pop(pop), .rdata(rdata), .rvalid(rvalid), .sp(sp),
                .stk_empty(stk_empty), .stk_full(stk_full), .err(err));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n++;
    assert (o === x) else begin
      nf++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic chk_all();
    chk("rvalid", {31'b0, rvalid}, {31'b0, mrv});
    if (mrdk) chk("rdata", {24'b0, rdata}, {24'b0, mrd});
    chk("sp", {24'b0, sp}, msp);
    chk("empty", {31'b0, stk_empty}, {31'b0, msp == 255});
    chk("full", {31'b0, stk_full}, {31'b0, msp == 223});
    chk("err", {28'b0, err}, {28'b0, me});
  endtask

  task automatic model_reset();
    msp = 255; me = 0; mrd = 0; mrv = 0; mrdk = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    {re, we, push, pop} = 4'b0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    chk_all();
  endtask

  task automatic step(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                      input bit pu, input bit po);
    int a2;
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d; push = pu; pop = po;
    @(posedge clk);
    mrv = 0;
    if (int'(r) + int'(w) + int'(pu) + int'(po) > 1) me[2] = 1;
    if (pu && po) ;
    else if (pu) begin
      if (msp == 223) me[0] = 1;
      else if (WP && msp < 128) me[3] = 1;
      else begin m[msp] = d; known[msp] = 1; msp--; end
    end else if (po) begin
      if (msp == 255) me[1] = 1;
      else begin a2 = msp + 1; mrd = m[a2]; mrdk = known[a2]; mrv = 1; msp++; end
    end else if (w) begin
      if (WP && a < 128) me[3] = 1;
      else begin m[a] = d; known[a] = 1; end
    end else if (r) begin
      mrd = m[a]; mrdk = known[a]; mrv = 1;
    end
    #1;
    chk_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    chk_all();
    for (int i = 0; i < 256; i++) step(0, 1, 8'(i), 8'($urandom), 0, 0);
    do_reset();
    step(0, 1, 8'h90, 8'h5A, 0, 0);
    step(1, 0, 8'h90, 8'h00, 0, 0);
    chk("wr_rd_data", {24'b0, rdata}, 32'h5A);
    step(0, 0, 8'h00, 8'h11, 1, 0);
    step(0, 0, 8'h00, 8'h22, 1, 0);
    chk("sp_after_push", {24'b0, sp}, 32'hFD);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    chk("pop1", {24'b0, rdata}, 32'h22);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    chk("pop2", {24'b0, rdata}, 32'h11);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    chk("underflow", {28'b0, err}, 32'h2);
    do_reset();
    for (int i = 0; i < 32; i++) step(0, 0, 8'h00, 8'(i + 1), 1, 0);
    chk("full32", {31'b0, stk_full}, 32'h1);
    step(0, 0, 8'h00, 8'hEE, 1, 0);
    chk("overflow_sp", {24'b0, sp}, 32'hDF);
    chk("overflow_err", {31'b0, err[0]}, 32'h1);
    do_reset();
    step(1, 0, 8'h90, 8'h33, 1, 0);
    step(0, 0, 8'h00, 8'h00, 1, 1);
    chk("conflict", {31'b0, err[2]}, 32'h1);
    do_reset();
    @(negedge clk);
    re = 1; addr = 8'h90;
    @(posedge clk);
    #2;
    re = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    chk_all();
    step(0, 0, 8'h00, 8'h00, 0, 0);
    do_reset();
    step(0, 1, 8'h10, 8'hAA, 0, 0);
    step(1, 0, 8'h10, 8'h00, 0, 0);
    chk("wprot_flag", {31'b0, err[3]}, {31'b0, WP});
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 59) do_reset();
      else step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 8'($urandom),
                8'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
    end
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
